stack_manager: RTL and testbench

//  Controller for the stack processor's operand stack. Top two entries live in registers
//  (top_of_stack, second_of_stack); deeper entries spill to an internal memory.

---
 rtl/stack_manager.sv | 178 +++++++++++++++++
 tb/tb_stack_manager.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/stack_manager.sv
// Operand stack controller: the top two entries are held in registers, deeper entries spill to a sync-RAM.
// Optional `STACK_CLEAR_EN adds a synchronous 'clear' input that empties the stack and keeps the error flags.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | accepting ops (op_ready=1)
// FILL  | refilling second_of_stack from mem read data (op_ready=0)
module stack_manager #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              CLK,
  input  logic              reset,
`ifdef STACK_CLEAR_EN
  input  logic              clear,
`endif
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] top_of_stack,
  output logic [DATA_W-1:0] second_of_stack,
  output logic [CNT_W-1:0]  depth,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam int MEM_D = DEPTH - 2;
  localparam int AW    = (MEM_D > 1) ? $clog2(MEM_D) : 1;

  localparam logic [2:0] OP_PUSH     = 3'b001;
  localparam logic [2:0] OP_POP      = 3'b010;
  localparam logic [2:0] OP_DUP      = 3'b011;
  localparam logic [2:0] OP_SWAP     = 3'b100;
  localparam logic [2:0] OP_REPLACE2 = 3'b101;

  localparam logic [CNT_W-1:0] D_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] D_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] D_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] D_THR  = CNT_W'(3);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   top_q, top_n;
  logic [DATA_W-1:0]   second_q, second_n;
  logic [CNT_W-1:0]    depth_q, depth_n;
  logic                ovf_q, ovf_n;
  logic                unf_q, unf_n;

  logic [DATA_W-1:0]   mem [MEM_D];
  logic [DATA_W-1:0]   rd_q;
  logic                mem_we, mem_re;
  logic [AW-1:0]       mem_waddr, mem_raddr;
  logic                clr;

`ifdef STACK_CLEAR_EN
  assign clr = clear;
`else
  assign clr = 1'b0;
`endif

  assign op_ready        = (state == S_IDLE) && !clr;
  assign top_of_stack    = top_q;
  assign second_of_stack = second_q;
  assign depth           = depth_q;
  assign err_overflow    = ovf_q;
  assign err_underflow   = unf_q;

  // Second moves to mem[d-2] on a push; mem[d-3] becomes the new second on a pop.
  assign mem_waddr = AW'(depth_q - D_TWO);
  assign mem_raddr = AW'(depth_q - D_THR);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      top_q    <= '0;
      second_q <= '0;
      depth_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state    <= state_n;
      top_q    <= top_n;
      second_q <= second_n;
      depth_q  <= depth_n;
      ovf_q    <= ovf_n;
      unf_q    <= unf_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= second_q;
    if (mem_re) rd_q <= mem[mem_raddr];
  end

  always_comb begin
    state_n  = state;
    top_n    = top_q;
    second_n = second_q;
    depth_n  = depth_q;
    ovf_n    = ovf_q;
    unf_n    = unf_q;
    mem_we   = 1'b0;
    mem_re   = 1'b0;

    if (clr) begin
      state_n  = S_IDLE;
      top_n    = '0;
      second_n = '0;
      depth_n  = '0;
    end else begin
      case (state)
        S_FILL: begin
          second_n = rd_q;
          state_n  = S_IDLE;
        end
        default: begin
          if (op_valid) begin
            case (op)
              OP_PUSH, OP_DUP: begin
                if (op == OP_DUP && depth_q == '0) begin
                  unf_n = 1'b1;
                end else if (depth_q == D_FULL) begin
                  ovf_n = 1'b1;
                end else begin
                  top_n    = (op == OP_DUP) ? top_q : wr_data;
                  second_n = top_q;
                  depth_n  = depth_q + D_ONE;
                  mem_we   = (depth_q >= D_TWO);
                end
              end
              OP_POP: begin
                if (depth_q == '0) begin
                  unf_n = 1'b1;
                end else begin
                  top_n   = second_q;
                  depth_n = depth_q - D_ONE;
                  if (depth_q >= D_THR) begin
                    mem_re  = 1'b1;
                    state_n = S_FILL;
                  end else begin
                    second_n = '0;
                  end
                end
              end
              OP_SWAP: begin
                if (depth_q < D_TWO) begin
                  unf_n = 1'b1;
                end else begin
                  top_n    = second_q;
                  second_n = top_q;
                end
              end
              OP_REPLACE2: begin
                if (depth_q < D_TWO) begin
                  unf_n = 1'b1;
                end else begin
                  top_n   = wr_data;
                  depth_n = depth_q - D_ONE;
                  if (depth_q >= D_THR) begin
                    mem_re  = 1'b1;
                    state_n = S_FILL;
                  end else begin
                    second_n = '0;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_manager.sv
// Directed bench for stack_manager at DEPTH=4: a per-cycle vector table plus short reset/FILL sequences.
module tb_stack_manager;

  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, DUP = 3'b011;
  localparam logic [2:0] SWAP = 3'b100, REPL = 3'b101, RSV = 3'b110;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op = NOP;
  logic [15:0] wr_data = '0;
  logic [15:0] top_of_stack, second_of_stack;
  logic [4:0]  depth;
  logic        err_overflow, err_underflow;

  int n_vec = 0;
  int n_bad = 0;

  stack_manager #(.DATA_W(16), .DEPTH(4), .CNT_W(5)) dut (
    .CLK(CLK),
    .reset(reset),
`ifdef STACK_CLEAR_EN
    .clear(clear),
`endif
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op(op),
    .wr_data(wr_data),
    .top_of_stack(top_of_stack),
    .second_of_stack(second_of_stack),
    .depth(depth),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [15:0] wd;
    logic        r;
    logic [15:0] t;
    logic [15:0] s;
    logic [4:0]  d;
    logic        o;
    logic        u;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [2:0] o_op, logic [15:0] wd, logic r,
                              logic [15:0] t, logic [15:0] s, logic [4:0] d, logic o, logic u);
    vec_t x;
    x.v = v; x.op = o_op; x.wd = wd; x.r = r; x.t = t; x.s = s; x.d = d; x.o = o; x.u = u;
    return x;
  endfunction

  task automatic check(string name, logic r, logic [15:0] t, logic [15:0] s,
                       logic [4:0] d, logic o, logic u);
    n_vec++;
    if (op_ready !== r || top_of_stack !== t || second_of_stack !== s ||
        depth !== d || err_overflow !== o || err_underflow !== u) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b top=%0d sec=%0d dep=%0d ovf=%b unf=%b, want rdy=%b top=%0d sec=%0d dep=%0d ovf=%b unf=%b",
               name, op_ready, top_of_stack, second_of_stack, depth, err_overflow, err_underflow,
               r, t, s, d, o, u);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1; op_valid = 1'b0; op = NOP; wr_data = '0;
    @(negedge CLK);
    reset = 1'b0;
  endtask

  task automatic cyc(logic v, logic [2:0] o_op, logic [15:0] wd);
    @(negedge CLK);
    op_valid = v; op = o_op; wr_data = wd;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Each row is one clock: inputs driven before the edge, outputs expected just after it.
    tbl.push_back(mk(1, PUSH, 1, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, PUSH, 2, 1, 2, 1, 2, 0, 0));
    tbl.push_back(mk(1, PUSH, 3, 1, 3, 2, 3, 0, 0));
    tbl.push_back(mk(1, POP,  0, 0, 2, 2, 2, 0, 0));
    tbl.push_back(mk(0, NOP,  0, 1, 2, 1, 2, 0, 0));
    tbl.push_back(mk(1, PUSH, 3, 1, 3, 2, 3, 0, 0));
    tbl.push_back(mk(1, PUSH, 4, 1, 4, 3, 4, 0, 0));
    tbl.push_back(mk(1, PUSH, 5, 1, 4, 3, 4, 1, 0));
    tbl.push_back(mk(1, SWAP, 0, 1, 3, 4, 4, 1, 0));
    tbl.push_back(mk(1, REPL, 9, 0, 9, 4, 3, 1, 0));
    tbl.push_back(mk(1, PUSH, 8, 1, 9, 2, 3, 1, 0));
    tbl.push_back(mk(1, PUSH, 8, 1, 8, 9, 4, 1, 0));
    tbl.push_back(mk(1, DUP,  0, 1, 8, 9, 4, 1, 0));
    tbl.push_back(mk(1, POP,  0, 0, 9, 9, 3, 1, 0));
    tbl.push_back(mk(1, POP,  0, 1, 9, 2, 3, 1, 0));
    tbl.push_back(mk(1, POP,  0, 0, 2, 2, 2, 1, 0));
    tbl.push_back(mk(0, NOP,  0, 1, 2, 1, 2, 1, 0));
    tbl.push_back(mk(1, POP,  0, 1, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, DUP,  0, 1, 1, 1, 2, 1, 0));
    tbl.push_back(mk(1, REPL, 5, 1, 5, 0, 1, 1, 0));
    tbl.push_back(mk(1, SWAP, 0, 1, 5, 0, 1, 1, 1));
    tbl.push_back(mk(1, POP,  0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, POP,  0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, RSV,  7, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, PUSH, 7, 1, 7, 0, 1, 1, 1));

    repeat (2) @(negedge CLK);
    reset = 1'b0;
    #1;
    check("reset_state", 1, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].op, tbl[i].wd);
      check($sformatf("vec%0d", i), tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].d, tbl[i].o, tbl[i].u);
    end

    // Underflow on an empty stack leaves overflow clear and the stack usable.
    do_reset();
    cyc(1, POP, 0);
    check("empty_pop", 1, 0, 0, 0, 0, 1);
    cyc(1, PUSH, 7);
    check("push_after_unf", 1, 7, 0, 1, 0, 1);

    // SWAP then REPLACE2 on 1,2,3 with the refill from mem[0].
    do_reset();
    cyc(1, PUSH, 1);
    cyc(1, PUSH, 2);
    cyc(1, PUSH, 3);
    cyc(1, SWAP, 0);
    check("swap_123", 1, 2, 3, 3, 0, 0);
    cyc(1, REPL, 9);
    check("repl_stall", 0, 9, 3, 2, 0, 0);
    cyc(0, NOP, 0);
    check("repl_fill", 1, 9, 1, 2, 0, 0);

    // Reset landing mid-FILL acts without waiting for a clock edge.
    do_reset();
    cyc(1, PUSH, 1);
    cyc(1, PUSH, 2);
    cyc(1, PUSH, 3);
    cyc(1, POP, 0);
    check("pop_enter_fill", 0, 2, 2, 2, 0, 0);
    #1 reset = 1'b1;
    #1;
    check("async_reset_fill", 1, 0, 0, 0, 0, 0);
    @(negedge CLK);
    reset = 1'b0; op_valid = 1'b0;
    @(posedge CLK);
    #1;
    check("post_reset_idle", 1, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
